// File: rtl/axil_reg_if.sv
// AXI4-Lite slave to simple level-handshake register bus bridge, one transaction at a time.
// Optional build macro AXIL_REG_IF_TIMEOUT_EN adds an SLVERR response when reg_ack never arrives.
module axil_reg_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,

    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic [STRB_WIDTH-1:0] reg_wstrb,
    output logic                  reg_wr_en,
    output logic                  reg_rd_en,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    input  logic                  reg_ack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_WRESP,
        S_RRESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t state;
    state_t state_next;
    logic   prio_write;
    logic   wr_pending;
    logic   rd_pending;
    logic   grant_wr;
    logic   grant_rd;
    logic   expired;
    logic   unused_ok;

    assign unused_ok = ^{s_axil_awprot, s_axil_arprot};

    // Gated by rst_n so no ready pulse can escape while reset is held.
    assign wr_pending = rst_n & s_axil_awvalid & s_axil_wvalid;
    assign rd_pending = rst_n & s_axil_arvalid;

`ifdef AXIL_REG_IF_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;

    assign expired = ((state == S_WRITE) || (state == S_READ)) && !reg_ack
                     && (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (((state == S_WRITE) || (state == S_READ)) && !reg_ack && !expired) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;
    assign expired = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_next = state;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        case (state)
            S_IDLE: begin
                if (wr_pending && (!rd_pending || prio_write)) begin
                    grant_wr   = 1'b1;
                    state_next = S_WRITE;
                end else if (rd_pending) begin
                    grant_rd   = 1'b1;
                    state_next = S_READ;
                end
            end
            S_WRITE: if (reg_ack || expired) state_next = S_WRESP;
            S_READ:  if (reg_ack || expired) state_next = S_RRESP;
            S_WRESP: if (s_axil_bready) state_next = S_IDLE;
            S_RRESP: if (s_axil_rready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign s_axil_awready = grant_wr;
    assign s_axil_wready  = grant_wr;
    assign s_axil_arready = grant_rd;
    assign reg_wr_en      = (state == S_WRITE);
    assign reg_rd_en      = (state == S_READ);
    assign s_axil_bvalid  = (state == S_WRESP);
    assign s_axil_rvalid  = (state == S_RRESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            prio_write   <= 1'b1;
            reg_addr     <= '0;
            reg_wdata    <= '0;
            reg_wstrb    <= '0;
            s_axil_bresp <= RESP_OKAY;
            s_axil_rresp <= RESP_OKAY;
            s_axil_rdata <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update on the same edge.
            state <= state_next;
            if (grant_wr) begin
                reg_addr   <= s_axil_awaddr;
                reg_wdata  <= s_axil_wdata;
                reg_wstrb  <= s_axil_wstrb;
                prio_write <= 1'b0;
            end
            if (grant_rd) begin
                reg_addr   <= s_axil_araddr;
                prio_write <= 1'b1;
            end
            // A real ack in the expiry cycle wins over the timeout.
            if (state == S_WRITE) begin
                if (reg_ack) begin
                    s_axil_bresp <= RESP_OKAY;
                end else if (expired) begin
                    s_axil_bresp <= RESP_SLVERR;
                end
            end
            if (state == S_READ) begin
                if (reg_ack) begin
                    s_axil_rdata <= reg_rdata;
                    s_axil_rresp <= RESP_OKAY;
                end else if (expired) begin
                    s_axil_rdata <= '0;
                    s_axil_rresp <= RESP_SLVERR;
                end
            end
        end
    end

endmodule

// File: tb/tb_axil_reg_if.sv
// Directed self-checking bench for axil_reg_if; inputs change and outputs are sampled near the falling edge.
module tb_axil_reg_if;

    logic        clk;
    logic        rst_n;
    logic [31:0] s_axil_awaddr;
    logic [2:0]  s_axil_awprot;
    logic        s_axil_awvalid;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata;
    logic [3:0]  s_axil_wstrb;
    logic        s_axil_wvalid;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready;
    logic [31:0] s_axil_araddr;
    logic [2:0]  s_axil_arprot;
    logic        s_axil_arvalid;
    logic        s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready;
    logic [31:0] reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_wstrb;
    logic        reg_wr_en;
    logic        reg_rd_en;
    logic [31:0] reg_rdata;
    logic        reg_ack;

    int errors = 0;
    int checks = 0;

    axil_reg_if #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .STRB_WIDTH(4),
        .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_axil_awaddr(s_axil_awaddr),
        .s_axil_awprot(s_axil_awprot),
        .s_axil_awvalid(s_axil_awvalid),
        .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata),
        .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid),
        .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp),
        .s_axil_bvalid(s_axil_bvalid),
        .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr),
        .s_axil_arprot(s_axil_arprot),
        .s_axil_arvalid(s_axil_arvalid),
        .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata),
        .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid),
        .s_axil_rready(s_axil_rready),
        .reg_addr(reg_addr),
        .reg_wdata(reg_wdata),
        .reg_wstrb(reg_wstrb),
        .reg_wr_en(reg_wr_en),
        .reg_rd_en(reg_rd_en),
        .reg_rdata(reg_rdata),
        .reg_ack(reg_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and park on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called on a falling edge while in WRITE; acks this cycle and retires the response.
    task automatic complete_write(input logic [31:0] a, input logic [31:0] d,
                                  input logic [3:0] s, input string tag);
        reg_ack = 1'b1;
        #1;
        check({tag, "_wr_en"}, 64'(reg_wr_en), 64'd1);
        check({tag, "_rd_en"}, 64'(reg_rd_en), 64'd0);
        check({tag, "_addr"},  64'(reg_addr),  64'(a));
        check({tag, "_wdata"}, 64'(reg_wdata), 64'(d));
        check({tag, "_wstrb"}, 64'(reg_wstrb), 64'(s));
        step();
        reg_ack = 1'b0;
        #1;
        check({tag, "_bvalid"},   64'(s_axil_bvalid), 64'd1);
        check({tag, "_bresp"},    64'(s_axil_bresp),  64'd0);
        check({tag, "_wr_en_lo"}, 64'(reg_wr_en),     64'd0);
        s_axil_bready = 1'b1;
        step();
        s_axil_bready = 1'b0;
        #1;
        check({tag, "_bvalid_lo"}, 64'(s_axil_bvalid), 64'd0);
    endtask

    task automatic complete_read(input logic [31:0] a, input logic [31:0] d, input string tag);
        reg_ack   = 1'b1;
        reg_rdata = d;
        #1;
        check({tag, "_rd_en"}, 64'(reg_rd_en), 64'd1);
        check({tag, "_wr_en"}, 64'(reg_wr_en), 64'd0);
        check({tag, "_addr"},  64'(reg_addr),  64'(a));
        step();
        reg_ack   = 1'b0;
        reg_rdata = 32'h0;
        #1;
        check({tag, "_rvalid"}, 64'(s_axil_rvalid), 64'd1);
        check({tag, "_rdata"},  64'(s_axil_rdata),  64'(d));
        check({tag, "_rresp"},  64'(s_axil_rresp),  64'd0);
        s_axil_rready = 1'b1;
        step();
        s_axil_rready = 1'b0;
        #1;
        check({tag, "_rvalid_lo"}, 64'(s_axil_rvalid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        s_axil_awaddr  = 32'h0;
        s_axil_awprot  = 3'b000;
        s_axil_awvalid = 1'b0;
        s_axil_wdata   = 32'h0;
        s_axil_wstrb   = 4'h0;
        s_axil_wvalid  = 1'b0;
        s_axil_bready  = 1'b0;
        s_axil_araddr  = 32'h0;
        s_axil_arprot  = 3'b000;
        s_axil_arvalid = 1'b0;
        s_axil_rready  = 1'b0;
        reg_rdata      = 32'h0;
        reg_ack        = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        check("rst_awready", 64'(s_axil_awready), 64'd0);
        check("rst_arready", 64'(s_axil_arready), 64'd0);
        check("rst_bvalid",  64'(s_axil_bvalid),  64'd0);
        check("rst_rvalid",  64'(s_axil_rvalid),  64'd0);
        check("rst_wr_en",   64'(reg_wr_en),      64'd0);
        check("rst_rd_en",   64'(reg_rd_en),      64'd0);
        check("rst_rdata",   64'(s_axil_rdata),   64'd0);
        check("rst_addr",    64'(reg_addr),       64'd0);
        step();
        rst_n = 1'b1;
        step();

        // Contention right after reset: write, read, write, read
        s_axil_awaddr  = 32'h100;
        s_axil_wdata   = 32'h1111_1111;
        s_axil_wstrb   = 4'hF;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        s_axil_araddr  = 32'h200;
        s_axil_arvalid = 1'b1;
        #1;
        check("arb1_awready", 64'(s_axil_awready), 64'd1);
        check("arb1_wready",  64'(s_axil_wready),  64'd1);
        check("arb1_arready", 64'(s_axil_arready), 64'd0);
        step();
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        complete_write(32'h100, 32'h1111_1111, 4'hF, "arb1");
        s_axil_awaddr  = 32'h104;
        s_axil_wdata   = 32'h2222_2222;
        s_axil_wstrb   = 4'h3;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        #1;
        check("arb2_arready", 64'(s_axil_arready), 64'd1);
        check("arb2_awready", 64'(s_axil_awready), 64'd0);
        step();
        s_axil_arvalid = 1'b0;
        complete_read(32'h200, 32'hAAAA_0001, "arb2");
        s_axil_araddr  = 32'h204;
        s_axil_arvalid = 1'b1;
        #1;
        check("arb3_awready", 64'(s_axil_awready), 64'd1);
        check("arb3_arready", 64'(s_axil_arready), 64'd0);
        step();
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        complete_write(32'h104, 32'h2222_2222, 4'h3, "arb3");
        #1;
        check("arb4_arready", 64'(s_axil_arready), 64'd1);
        check("arb4_awready", 64'(s_axil_awready), 64'd0);
        step();
        s_axil_arvalid = 1'b0;
        complete_read(32'h204, 32'hAAAA_0002, "arb4");

        // Minimum-latency write
        s_axil_awaddr  = 32'h10;
        s_axil_wdata   = 32'hCAFE_BABE;
        s_axil_wstrb   = 4'hF;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        #1;
        check("wr_awready", 64'(s_axil_awready), 64'd1);
        check("wr_wready",  64'(s_axil_wready),  64'd1);
        step();
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        complete_write(32'h10, 32'hCAFE_BABE, 4'hF, "wr");

        // Address without data for five cycles
        s_axil_awaddr  = 32'h14;
        s_axil_wdata   = 32'h0BAD_F00D;
        s_axil_wstrb   = 4'h5;
        s_axil_awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("awonly_awready", 64'(s_axil_awready), 64'd0);
            check("awonly_wready",  64'(s_axil_wready),  64'd0);
            step();
        end
        s_axil_wvalid = 1'b1;
        #1;
        check("aw_w_awready", 64'(s_axil_awready), 64'd1);
        check("aw_w_wready",  64'(s_axil_wready),  64'd1);
        step();
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        #1;
        check("aw_w_awready_lo", 64'(s_axil_awready), 64'd0);
        complete_write(32'h14, 32'h0BAD_F00D, 4'h5, "aw_w");

        // Read with late ack and back-pressured response
        s_axil_araddr  = 32'h20;
        s_axil_arvalid = 1'b1;
        #1;
        check("rd_arready", 64'(s_axil_arready), 64'd1);
        step();
        s_axil_arvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rd_wait_rd_en",  64'(reg_rd_en),     64'd1);
            check("rd_wait_addr",   64'(reg_addr),      64'h20);
            check("rd_wait_rvalid", 64'(s_axil_rvalid), 64'd0);
            step();
        end
        reg_ack   = 1'b1;
        reg_rdata = 32'h1234_5678;
        #1;
        check("rd_ack_rd_en", 64'(reg_rd_en), 64'd1);
        step();
        reg_ack   = 1'b0;
        reg_rdata = 32'hDEAD_DEAD;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rd_hold_rvalid", 64'(s_axil_rvalid), 64'd1);
            check("rd_hold_rdata",  64'(s_axil_rdata),  64'h1234_5678);
            check("rd_hold_rresp",  64'(s_axil_rresp),  64'd0);
            check("rd_hold_rd_en",  64'(reg_rd_en),     64'd0);
            step();
        end
        s_axil_rready = 1'b1;
        step();
        s_axil_rready = 1'b0;
        #1;
        check("rd_rvalid_lo", 64'(s_axil_rvalid), 64'd0);
        reg_rdata = 32'h0;

        // Write that is never acknowledged
        s_axil_awaddr  = 32'h30;
        s_axil_wdata   = 32'h5555_AAAA;
        s_axil_wstrb   = 4'hF;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        step();
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
`ifdef AXIL_REG_IF_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            #1;
            check("to_wr_en", 64'(reg_wr_en), 64'd1);
            check("to_bvalid_lo", 64'(s_axil_bvalid), 64'd0);
            step();
        end
        #1;
        check("to_wr_en_lo", 64'(reg_wr_en),     64'd0);
        check("to_bvalid",   64'(s_axil_bvalid), 64'd1);
        check("to_bresp",    64'(s_axil_bresp),  64'd2);
        s_axil_bready = 1'b1;
        step();
        s_axil_bready = 1'b0;
        #1;
        check("to_bvalid_done", 64'(s_axil_bvalid), 64'd0);
`else
        for (int i = 0; i < 100; i++) step();
        #1;
        check("noto_wr_en",  64'(reg_wr_en),     64'd1);
        check("noto_bvalid", 64'(s_axil_bvalid), 64'd0);
        rst_n = 1'b0;
        #1;
        check("noto_rst_wr_en", 64'(reg_wr_en), 64'd0);
        step();
        rst_n = 1'b1;
        step();
`endif

        // Reset in the middle of a read
        s_axil_araddr  = 32'h40;
        s_axil_arvalid = 1'b1;
        step();
        s_axil_arvalid = 1'b0;
        #1;
        check("rrst_rd_en_pre", 64'(reg_rd_en), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rrst_rd_en",  64'(reg_rd_en),      64'd0);
        check("rrst_addr",   64'(reg_addr),       64'd0);
        check("rrst_wdata",  64'(reg_wdata),      64'd0);
        check("rrst_wstrb",  64'(reg_wstrb),      64'd0);
        check("rrst_rvalid", 64'(s_axil_rvalid),  64'd0);
        check("rrst_rdata",  64'(s_axil_rdata),   64'd0);
        check("rrst_bresp",  64'(s_axil_bresp),   64'd0);
        check("rrst_rresp",  64'(s_axil_rresp),   64'd0);
        check("rrst_arready", 64'(s_axil_arready), 64'd0);
        step();
        rst_n         = 1'b1;
        reg_ack       = 1'b1;
        reg_rdata     = 32'hFFFF_0000;
        s_axil_rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rrst_post_rvalid", 64'(s_axil_rvalid), 64'd0);
            check("rrst_post_rd_en",  64'(reg_rd_en),     64'd0);
            check("rrst_post_bvalid", 64'(s_axil_bvalid), 64'd0);
            step();
        end
        reg_ack       = 1'b0;
        s_axil_rready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
